display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 4, clk cycles per PWM step (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port ena  input  1  design enable; low forces IDLE.
REQ-005 SHALL have port digit1  input  4  units value, BCD.
REQ-006 SHALL have port digit10  input  4  tens value, BCD.
REQ-007 SHALL have port duty  input  7  brightness, lit steps per 128-step slot.
REQ-008 SHALL have port duty_valid  input  1  one-cycle strobe capturing duty.
REQ-009 SHALL have port seg_pol  input  1  segment lit level (1 = active high).
REQ-010 SHALL have port com_pol  input  1  common active level (1 = active high).
REQ-011 SHALL have port blank10  input  1  leading-zero blanking enable for tens digit.
REQ-012 SHALL have port seg  output  8  segments {dp,g,f,e,d,c,b,a}.
REQ-013 SHALL have port com1  output  1  units digit common.
REQ-014 SHALL have port com10  output  1  tens digit common.
REQ-015 SHALL have port com_oe  output  2  output enables {com10,com1}.
REQ-016 SHALL have port frame_tick  output  1  one-cycle pulse at frame start.

Function
REQ-017 SHALL implement states IDLE, SLOT1, SLOT10; IDLE->SLOT1 when ena=1; SLOT1->SLOT10 and SLOT10->SLOT1 after step 127 completes; any state->IDLE when ena=0 (next edge).
REQ-018 SHALL use prescaler 0..PRESCALE-1 and 7-bit step counter 0..127; step advances when prescaler wraps; both cleared on entry to SLOT1 from IDLE and on every slot change; each slot lasts exactly 128*PRESCALE cycles.
REQ-019 SHALL pulse frame_tick for exactly one cycle on the first cycle of every SLOT1 (including entry from IDLE); same cycle latches digit1/digit10 into shadow registers and pending duty into active duty.
REQ-020 SHALL capture duty into pending register on any cycle with duty_valid=1; if duty_valid coincides with frame_tick cycle, active duty takes incoming duty directly.
REQ-021 SHALL light the slot's digit only when step != 0 and step <= active duty; step 0 is dead time (both commons inactive, segments unlit); duty=0 never lights, duty=127 lights 127/128.
REQ-022 SHALL decode shadow value 0..9 to gfedcba patterns 3F,06,5B,4F,66,6D,7D,07,7F,6F with dp=0; values 10..15 decode to 00.
REQ-023 SHALL blank SLOT10 entirely (segments unlit, com10 inactive) when blank10=1 and shadow digit10=0.
REQ-024 SHALL drive seg = pattern when seg_pol=1, ~pattern when seg_pol=0; unlit segments at ~seg_pol level.
REQ-025 SHALL drive active common at com_pol, inactive at ~com_pol; at most one common active in any cycle; com1 active only in SLOT1, com10 only in SLOT10.
REQ-026 SHALL drive com_oe=2'b11 whenever state != IDLE, 2'b00 in IDLE.
REQ-027 SHALL make seg/com outputs functions of registered state plus polarity inputs only (polarity change takes effect same cycle, no glitch on state).
REQ-028 SHALL ignore digit input changes mid-frame (no tearing); changes appear from next frame_tick.

Reset
REQ-029 SHALL on rst_n=0 immediately enter IDLE, clear prescaler, step, shadows (0), frame_tick=0, pending and active duty = 7'h40.
REQ-030 SHALL in reset/IDLE hold com_oe=00, both commons at ~com_pol, seg at ~seg_pol level.
REQ-031 SHALL on reset mid-slot abort without completing slot; first frame_tick occurs on first edge with rst_n=1 and ena=1.

Verification (PRESCALE=4)
REQ-032 SHALL verify: reset release, ena=1, digit1=7, digit10=4, duty default -> frame_tick every 1024 cycles; com1 active steps 1..64 of SLOT1, seg=07 (seg_pol=1); com10 active steps 1..64 of SLOT10, seg=66.
REQ-033 SHALL verify: duty_valid with duty=1 mid-frame -> unchanged current frame; next frame each digit lit exactly 4 cycles (step 1); duty=127 -> 508 cycles; duty=0 -> never lit.
REQ-034 SHALL verify: blank10=1, digit10=0, digit1=5 -> com10 never active, SLOT10 seg unlit; digit10=0 with blank10=0 -> seg=3F; digit1=12 -> seg=00.
REQ-035 SHALL verify: seg_pol=0, com_pol=0, digit1=8 -> seg=80 while lit, com1=0 active, com10=1; never both commons active over 10 frames.
REQ-036 SHALL verify: digit1 changed 3->9 at step 30 of SLOT1 -> remains 4F until next frame_tick, then 6F.
REQ-037 SHALL verify: ena=0 mid-SLOT10 -> next edge IDLE, com_oe=00; rst_n pulse mid-SLOT1 -> immediate IDLE outputs, active duty back to 40.

Source files
------------

// File: rtl/display_scan_ctrl_if.sv
// Bundle of the control inputs and display drive outputs of display_scan_ctrl.
// clk and rst_n are plain module ports and are not part of this bundle.
interface display_scan_ctrl_if;
  logic       ena;
  logic [3:0] digit1;
  logic [3:0] digit10;
  logic [6:0] duty;
  logic       duty_valid;
  logic       seg_pol;
  logic       com_pol;
  logic       blank10;
  logic [7:0] seg;
  logic       com1;
  logic       com10;
  logic [1:0] com_oe;
  logic       frame_tick;

  modport master (
    output ena, digit1, digit10, duty, duty_valid, seg_pol, com_pol, blank10,
    input  seg, com1, com10, com_oe, frame_tick
  );

  modport slave (
    input  ena, digit1, digit10, duty, duty_valid, seg_pol, com_pol, blank10,
    output seg, com1, com10, com_oe, frame_tick
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Two-digit multiplexed 7-segment scanner with PWM brightness.
// Each frame has a units slot followed by a tens slot, and each slot has 128 PWM steps.
module display_scan_ctrl #(
  parameter int unsigned PRESCALE = 4
) (
  input logic               clk,
  input logic               rst_n,
  display_scan_ctrl_if.slave bus
);
  localparam logic [6:0] DUTY_RST = 7'h40;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, SLOT1, SLOT10} state_t;

  state_t        r_state, w_state_next;
  logic [PW-1:0] r_presc, w_presc_next;
  logic [6:0]    r_step, w_step_next;
  logic          r_frame_tick, w_frame_start;
  logic [3:0]    r_shadow1, r_shadow10;
  logic          r_blank10;
  logic [6:0]    r_duty_pend, r_duty_act;

  always_comb begin
    w_state_next = r_state;
    w_presc_next = r_presc;
    w_step_next  = r_step;
    if (!bus.ena) begin
      w_state_next = IDLE;
      w_presc_next = '0;
      w_step_next  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_next = SLOT1;
          w_presc_next = '0;
          w_step_next  = '0;
        end
        default: begin
          if (r_presc == PRESC_MAX) begin
            w_presc_next = '0;
            // Step 127 wraps to 0, which is also the dead-time step of the next slot.
            w_step_next  = r_step + 7'd1;
            if (r_step == 7'd127) begin
              w_state_next = (r_state == SLOT1) ? SLOT10 : SLOT1;
            end
          end else begin
            w_presc_next = r_presc + PW'(1);
          end
        end
      endcase
    end
  end

  assign w_frame_start = (w_state_next == SLOT1) && (r_state != SLOT1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_presc      <= '0;
      r_step       <= '0;
      r_frame_tick <= 1'b0;
      r_shadow1    <= '0;
      r_shadow10   <= '0;
      r_blank10    <= 1'b0;
      r_duty_pend  <= DUTY_RST;
      r_duty_act   <= DUTY_RST;
    end else begin
      r_state      <= w_state_next;
      r_presc      <= w_presc_next;
      r_step       <= w_step_next;
      r_frame_tick <= w_frame_start;
      if (bus.duty_valid) begin
        r_duty_pend <= bus.duty;
      end
      // Frame-start cycle is dead time, so refreshing the shadows here cannot tear a lit digit.
      if (r_frame_tick) begin
        r_shadow1  <= bus.digit1;
        r_shadow10 <= bus.digit10;
        r_blank10  <= bus.blank10;
        r_duty_act <= bus.duty_valid ? bus.duty : r_duty_pend;
      end
    end
  end

  logic       w_slot10;
  logic [3:0] w_digit;
  logic       w_blank;
  logic       w_lit;
  logic [6:0] w_pattern;
  logic [7:0] w_seg_lit;

  assign w_slot10 = (r_state == SLOT10);
  assign w_digit  = w_slot10 ? r_shadow10 : r_shadow1;
  assign w_blank  = w_slot10 && r_blank10 && (r_shadow10 == 4'd0);
  assign w_lit    = (r_state != IDLE) && (r_step != 7'd0) && (r_step <= r_duty_act) && !w_blank;

  always_comb begin
    w_pattern = 7'h00;
    case (w_digit)
      4'd0: w_pattern = 7'h3F;
      4'd1: w_pattern = 7'h06;
      4'd2: w_pattern = 7'h5B;
      4'd3: w_pattern = 7'h4F;
      4'd4: w_pattern = 7'h66;
      4'd5: w_pattern = 7'h6D;
      4'd6: w_pattern = 7'h7D;
      4'd7: w_pattern = 7'h07;
      4'd8: w_pattern = 7'h7F;
      4'd9: w_pattern = 7'h6F;
      default: w_pattern = 7'h00;
    endcase
  end

  // Polarity is applied last so a polarity change shows up in the same cycle.
  assign w_seg_lit  = w_lit ? {1'b0, w_pattern} : 8'h00;
  assign bus.seg    = w_seg_lit ^ {8{~bus.seg_pol}};
  assign bus.com1   = ~((w_lit && (r_state == SLOT1)) ^ bus.com_pol);
  assign bus.com10  = ~((w_lit && w_slot10) ^ bus.com_pol);
  assign bus.com_oe = (r_state != IDLE) ? 2'b11 : 2'b00;
  assign bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized and directed bench for display_scan_ctrl against a frame-position reference model.
module tb_display_scan_ctrl;
  localparam int P        = 4;
  localparam int SLOT_LEN = 128 * P;
  localparam int FRAME    = 2 * SLOT_LEN;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  display_scan_ctrl_if bus();

  display_scan_ctrl #(.PRESCALE(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] lut [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: position inside the frame, plus the values latched at each frame start.
  bit         m_run;
  int         m_t;
  int         m_sh1, m_sh10;
  bit         m_bl;
  int         m_pend, m_act;

  task automatic model_reset();
    m_run = 0; m_t = 0; m_sh1 = 0; m_sh10 = 0; m_bl = 0; m_pend = 64; m_act = 64;
  endtask

  task automatic model_update();
    if (!rst_n) return;
    if (m_run && m_t == 0) begin
      m_sh1  = int'(bus.digit1);
      m_sh10 = int'(bus.digit10);
      m_bl   = bus.blank10;
      m_act  = bus.duty_valid ? int'(bus.duty) : m_pend;
    end
    if (bus.duty_valid) m_pend = int'(bus.duty);
    if (!bus.ena) begin
      m_run = 0; m_t = 0;
    end else if (!m_run) begin
      m_run = 1; m_t = 0;
    end else begin
      m_t = (m_t + 1) % FRAME;
    end
  endtask

  function automatic logic [12:0] model_outs();
    int step, d;
    bit s10, lit;
    logic [7:0] p, seg;
    logic c1, c10;
    s10  = (m_t >= SLOT_LEN);
    step = (m_t % SLOT_LEN) / P;
    lit  = m_run && step != 0 && step <= m_act && !(s10 && m_bl && m_sh10 == 0);
    d    = s10 ? m_sh10 : m_sh1;
    p    = (d < 10) ? lut[d] : 8'h00;
    seg  = lit ? (bus.seg_pol ? p : ~p) : (bus.seg_pol ? 8'h00 : 8'hFF);
    c1   = (lit && !s10) ? bus.com_pol : ~bus.com_pol;
    c10  = (lit && s10) ? bus.com_pol : ~bus.com_pol;
    return {seg, c1, c10, (m_run ? 2'b11 : 2'b00), (m_run && m_t == 0)};
  endfunction

  function automatic logic [12:0] outs();
    return {bus.seg, bus.com1, bus.com10, bus.com_oe, bus.frame_tick};
  endfunction

  int c1, c10, both, nft, cyc, last_ft, gap;
  logic [7:0] seg1, seg10;

  task automatic clr();
    c1 = 0; c10 = 0; both = 0; nft = 0; seg1 = 8'hAA; seg10 = 8'hAA;
  endtask

  // Entered at (or just after) a falling edge; leaves at a falling edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      check("outs", 32'(outs()), 32'(model_outs()));
      if (bus.com1 == bus.com_pol) begin c1++; seg1 = bus.seg; end
      if (bus.com10 == bus.com_pol) begin c10++; seg10 = bus.seg; end
      if (bus.com1 == bus.com_pol && bus.com10 == bus.com_pol) both++;
      if (bus.frame_tick) begin
        if (last_ft >= 0) gap = cyc - last_ft;
        last_ft = cyc;
        nft++;
      end
      @(posedge clk);
      model_update();
      cyc++;
      @(negedge clk);
      bus.duty_valid = 1'b0;
    end
  endtask

  task automatic strobe(input int d);
    bus.duty = 7'(d);
    bus.duty_valid = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ena = 0; bus.digit1 = 0; bus.digit10 = 0; bus.duty = 0; bus.duty_valid = 0;
    bus.seg_pol = 1; bus.com_pol = 1; bus.blank10 = 0;
    model_reset();
    cyc = 0; last_ft = -1; gap = 0;
    clr();

    @(negedge clk); #1;
    check("reset_outs", 32'(outs()), 32'd0);
    @(negedge clk);
    $display("txn reset released");

    // Default duty, digits 74
    rst_n = 1; bus.ena = 1; bus.digit1 = 7; bus.digit10 = 4;
    run(1);
    clr(); run(FRAME);
    check("default_on1", 32'(c1), 32'd256);
    check("default_on10", 32'(c10), 32'd256);
    check("seg_digit7", 32'(seg1), 32'h07);
    check("seg_digit4", 32'(seg10), 32'h66);
    check("ticks_per_frame", 32'(nft), 32'd1);
    run(FRAME);
    check("frame_period", 32'(gap), 32'd1024);
    $display("txn default frames");

    // Duty changes: mid-frame strobe is deferred, strobe on frame_tick is immediate
    clr(); run(300); strobe(1); run(FRAME - 300);
    check("midframe_hold1", 32'(c1), 32'd256);
    check("midframe_hold10", 32'(c10), 32'd256);
    clr(); run(FRAME);
    check("duty1_on1", 32'(c1), 32'd4);
    check("duty1_on10", 32'(c10), 32'd4);
    clr(); strobe(127); run(FRAME);
    check("duty127_on1", 32'(c1), 32'd508);
    check("duty127_on10", 32'(c10), 32'd508);
    clr(); run(100); strobe(0); run(FRAME - 100);
    check("duty0_hold", 32'(c1), 32'd508);
    clr(); run(FRAME);
    check("duty0_on1", 32'(c1), 32'd0);
    check("duty0_on10", 32'(c10), 32'd0);
    $display("txn duty sweep");

    // Blanking and decode edge cases
    strobe(64); bus.blank10 = 1; bus.digit10 = 0; bus.digit1 = 5;
    clr(); run(FRAME);
    check("blank_on10", 32'(c10), 32'd0);
    check("blank_on1", 32'(c1), 32'd256);
    check("seg_digit5", 32'(seg1), 32'h6D);
    bus.blank10 = 0;
    clr(); run(FRAME);
    check("noblank_seg0", 32'(seg10), 32'h3F);
    bus.digit1 = 12;
    clr(); run(FRAME);
    check("seg_digit12", 32'(seg1), 32'h00);
    $display("txn blanking/decode");

    // Inverted polarities
    bus.seg_pol = 0; bus.com_pol = 0; bus.digit1 = 8;
    clr(); run(FRAME);
    check("inv_seg8", 32'(seg1), 32'h80);
    check("inv_on1", 32'(c1), 32'd256);
    clr();
    for (int f = 0; f < 10; f++) begin
      bus.digit1  = 4'($urandom_range(0, 15));
      bus.digit10 = 4'($urandom_range(0, 15));
      bus.blank10 = 1'($urandom_range(0, 1));
      bus.seg_pol = 1'($urandom_range(0, 1));
      bus.com_pol = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) strobe(int'($urandom_range(0, 127)));
      run(437);
      strobe(int'($urandom_range(0, 127)));
      run(FRAME - 437);
    end
    check("never_both_active", 32'(both), 32'd0);
    $display("txn random frames");

    // Digit change mid-frame must not tear
    bus.seg_pol = 1; bus.com_pol = 1; bus.blank10 = 0; strobe(64); bus.digit1 = 3;
    clr(); run(120); bus.digit1 = 9; run(FRAME - 120);
    check("no_tear_seg3", 32'(seg1), 32'h4F);
    clr(); run(FRAME);
    check("next_frame_seg9", 32'(seg1), 32'h6F);
    $display("txn tearing");

    // Disable mid-SLOT10, then reset mid-SLOT1
    run(SLOT_LEN + 100);
    bus.ena = 0;
    run(1);
    #1;
    check("ena_off_oe", 32'(bus.com_oe), 32'd0);
    strobe(20); bus.ena = 1;
    run(1);
    run(1 + 4 * 50);
    rst_n = 0; model_reset(); #1;
    check("rst_mid_outs", 32'(outs()), 32'd0);
    @(negedge clk);
    rst_n = 1;
    run(1);
    clr(); run(FRAME);
    check("rst_duty_default", 32'(c1), 32'd256);
    check("rst_first_tick", 32'(nft), 32'd1);
    $display("txn disable/reset");

    // Random soak with enable drops and reset pulses
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        rst_n = 0; model_reset();
      end else begin
        rst_n = 1;
      end
      if (r >= 3 && r < 8) bus.ena = ~bus.ena;
      if (!bus.ena && r > 900) bus.ena = 1;
      if (r >= 100 && r < 130) strobe(int'($urandom_range(0, 127)));
      if (r >= 200 && r < 220) bus.digit1 = 4'($urandom_range(0, 15));
      if (r >= 300 && r < 320) bus.digit10 = 4'($urandom_range(0, 15));
      if (r >= 400 && r < 405) bus.blank10 = ~bus.blank10;
      if (r >= 500 && r < 503) bus.seg_pol = ~bus.seg_pol;
      if (r >= 600 && r < 603) bus.com_pol = ~bus.com_pol;
      run(1);
    end
    $display("txn random soak");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
